// File: rtl/muldiv_ctrl.sv
// Iterative multiply/divide sequencer: shift-add MULT/MULTU, restoring DIV/DIVU.
// Ports: clk, rst(async low), start/op/srca/srcb/flush in; stall/busy/done/hilowrite/hi/lo/divzero out.
module muldiv_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  input  logic             flush,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic             hilowrite,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             divzero
);

  localparam int CW = $clog2(WIDTH);
  localparam int W2 = 2 * WIDTH;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic [CW-1:0]    count;
  logic [W2-1:0]    acc;
  logic [WIDTH-1:0] opnd;
  logic             op_div;
  logic             neg_res;
  logic             neg_rem;
  logic             dz_q;

  logic             accept;
  logic             divz;
  logic             last;
  logic             sa, sb;
  logic [WIDTH-1:0] absa, absb;
  logic [WIDTH:0]   msum;
  logic [WIDTH:0]   rshift;
  logic [WIDTH:0]   rdiff;
  logic [W2-1:0]    acc_n;
  logic [W2-1:0]    prod;
  logic [WIDTH-1:0] quo, rem;

  assign accept = start & ~flush;
  assign divz   = op[1] & (srcb == '0);
  assign last   = (count == CW'(WIDTH - 1));

  // Signed ops work on magnitudes; signs are restored at the end.
  assign sa   = ~op[0] & srca[WIDTH-1];
  assign sb   = ~op[0] & srcb[WIDTH-1];
  assign absa = sa ? -srca : srca;
  assign absb = sb ? -srcb : srcb;

  // acc holds {partial product, multiplier} or {remainder, dividend/quotient}.
  always_comb begin
    msum   = {1'b0, acc[W2-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
    rshift = {acc[W2-1:WIDTH], acc[WIDTH-1]};
    rdiff  = rshift - {1'b0, opnd};
    if (op_div) begin
      if (rdiff[WIDTH])
        acc_n = {rshift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      else
        acc_n = {rdiff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    end else begin
      acc_n = {msum, acc[WIDTH-1:1]};
    end
    prod = neg_res ? -acc_n : acc_n;
    quo  = neg_res ? -acc_n[WIDTH-1:0] : acc_n[WIDTH-1:0];
    rem  = neg_rem ? -acc_n[W2-1:WIDTH] : acc_n[W2-1:WIDTH];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept) state_d = divz ? DONE : BUSY;
      BUSY: if (flush) state_d = IDLE;
            else if (last) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count   <= '0;
      acc     <= '0;
      opnd    <= '0;
      op_div  <= 1'b0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      dz_q    <= 1'b0;
      hi      <= '0;
      lo      <= '0;
    end else if (state_q == IDLE && accept) begin
      count   <= '0;
      op_div  <= op[1];
      neg_res <= sa ^ sb;
      neg_rem <= sa;
      dz_q    <= divz;
      opnd    <= op[1] ? absb : absa;
      acc     <= {{WIDTH{1'b0}}, op[1] ? absa : absb};
      if (divz) begin
        hi <= srca;
        lo <= '1;
      end
    end else if (state_q == BUSY && !flush) begin
      count <= count + 1'b1;
      acc   <= acc_n;
      if (last) begin
        hi <= op_div ? rem : prod[W2-1:WIDTH];
        lo <= op_div ? quo : prod[WIDTH-1:0];
      end
    end
  end

  assign stall     = (state_q == IDLE & accept) | (state_q == BUSY);
  assign busy      = (state_q == BUSY) | (state_q == DONE);
  assign done      = (state_q == DONE) & ~flush;
  assign hilowrite = done;
  assign divzero   = done & dz_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl.
// Vectors with hand-computed hi/lo, latency and handshake checks.
module tb_muldiv_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] srca, srcb;
  logic        flush;
  logic        stall, busy, done, hilowrite, divzero;
  logic [31:0] hi, lo;

  int npass = 0;
  int ntot  = 0;

  muldiv_ctrl #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op),
    .srca(srca), .srcb(srcb), .flush(flush),
    .stall(stall), .busy(busy), .done(done),
    .hilowrite(hilowrite), .hi(hi), .lo(lo),
    .divzero(divzero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    ntot++;
    if (got === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start an op, wait for done (bounded); returns edges to done and
  // number of cycles stall was seen high before the done cycle.
  task automatic issue(input logic [1:0] o,
                       input logic [31:0] a,
                       input logic [31:0] b,
                       output int lat,
                       output int stalls);
    op = o; srca = a; srcb = b; start = 1'b1;
    lat = 0; stalls = 0;
    #1;
    while (!done && lat < 100) begin
      if (stall) stalls++;
      tick();
      start = 1'b0;
      #1;
      lat++;
    end
    start = 1'b0;
  endtask

  int lat, stalls, writes, n;

  initial begin
    rst = 1'b0; start = 1'b0; flush = 1'b0;
    op = 2'b00; srca = '0; srcb = '0;
    #12;
    chk("rst_stall", stall, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_hl", {hi, lo}, 64'h0);
    chk("rst_dz", divzero, 0);
    tick();
    rst = 1'b1;
    tick();

    // reset mid-op
    op = 2'b01; srca = 32'h12345678; srcb = 32'h9ABCDEF0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    chk("pre_rst_busy", busy, 1);
    rst = 1'b0;
    #1;
    chk("midrst_stall", stall, 0);
    chk("midrst_busy", busy, 0);
    writes = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (hilowrite) writes++;
    end
    rst = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (hilowrite) writes++;
    end
    chk("midrst_nowr", writes, 0);

    issue(2'b01, 32'h12345678, 32'h9ABCDEF0, lat, stalls);
    chk("multu_lat", lat, 33);
    chk("multu_hl", {hi, lo}, 64'h0B00EA4E_242D2080);
    tick();
    chk("multu_1shot", done, 0);

    // MULT -3 * 7
    issue(2'b00, 32'hFFFFFFFD, 32'h00000007, lat, stalls);
    chk("mult_hl", {hi, lo}, 64'hFFFFFFFF_FFFFFFEB);
    chk("mult_stalls", stalls, 33);
    chk("mult_done_stall", stall, 0);
    chk("mult_wr", hilowrite, 1);
    chk("mult_dz", divzero, 0);
    tick();

    // DIV -7 / 2
    issue(2'b10, 32'hFFFFFFF9, 32'h00000002, lat, stalls);
    chk("div_hl", {hi, lo}, 64'hFFFFFFFF_FFFFFFFD);
    chk("div_lat", lat, 33);
    tick();

    // DIVU 100 / 0
    issue(2'b11, 32'h00000064, 32'h0, lat, stalls);
    chk("dz_lat", lat, 1);
    chk("dz_hl", {hi, lo}, 64'h00000064_FFFFFFFF);
    chk("dz_flag", divzero, 1);
    tick();
    chk("dz_clear", divzero, 0);

    // overflow divide
    issue(2'b10, 32'h80000000, 32'hFFFFFFFF, lat, stalls);
    chk("ovf_hl", {hi, lo}, 64'h00000000_80000000);
    tick();

    // flush at count 5
    op = 2'b01; srca = 32'd5; srcb = 32'd6; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    #1;
    chk("fl_busy", busy, 0);
    writes = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (hilowrite) writes++;
    end
    chk("fl_nowr", writes, 0);
    chk("fl_keep", {hi, lo}, 64'h00000000_80000000);

    // start+flush in IDLE
    op = 2'b11; srca = 32'd9; srcb = 32'd3;
    start = 1'b1; flush = 1'b1;
    #1;
    chk("sf_stall", stall, 0);
    tick();
    chk("sf_busy", busy, 0);
    start = 1'b0; flush = 1'b0;
    tick();

    // start held across DONE: DIVU 100/7 = 14 r 2
    op = 2'b11; srca = 32'd100; srcb = 32'd7; start = 1'b1;
    writes = 0; n = 0;
    #1;
    while (!done && n < 100) begin
      tick();
      n++;
    end
    if (hilowrite) writes++;
    chk("hold_lat", n, 33);
    chk("hold_hl", {hi, lo}, 64'h00000002_0000000E);
    chk("hold_done_stall", stall, 0);
    tick();
    chk("hold_idle_busy", busy, 0);
    chk("hold_idle_stall", stall, 1);
    tick();
    chk("hold_rebusy", busy, 1);
    start = 1'b0;
    n = 0;
    while (n < 60) begin
      tick();
      if (hilowrite) writes++;
      n++;
    end
    chk("hold_writes", writes, 2);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule

// File: doc/muldiv_ctrl.md
Name: muldiv_ctrl

Overview:
- Iterative multi-cycle multiply/divide sequencer for the execute stage.
- Accepts MULT/MULTU/DIV/DIVU from the execute stage and runs a shift-add (multiply) or restoring shift-subtract (divide) engine, one bit per cycle.
- Holds the pipeline stalled through the operation, then issues a one-cycle write strobe with {hi, lo} to the HI/LO register.

Parameters:
- WIDTH, 32, operand width; also the iteration count per operation.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-low reset
- start  input  1  execute stage holds a mult/div op this cycle
- op  input  2  00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU
- srca  input  WIDTH  multiplicand / dividend (forwarded value)
- srcb  input  WIDTH  multiplier / divisor (forwarded value)
- flush  input  1  cancel any op in flight (exception/flushE)
- stall  output  1  freeze F/D/E stages
- busy  output  1  engine occupied (BUSY or DONE state)
- done  output  1  one-cycle result-valid pulse
- hilowrite  output  1  HI/LO write enable; equals done
- hi  output  WIDTH  MULT: product[2W-1:W]; DIV: remainder
- lo  output  WIDTH  MULT: product[W-1:0]; DIV: quotient
- divzero  output  1  with done: divisor was zero

Behaviour:
- States: IDLE, BUSY, DONE. Reset (rst=0, async) forces IDLE, counter=0, all outputs 0, hi=lo=0. Reset mid-operation discards the op with no write.
- IDLE: start=1 and flush=0 latches op, sign flags, and |srca|,|srcb| (absolute values for signed ops, raw for unsigned); count=0; next state BUSY. Exception: DIV/DIVU with srcb=0 goes straight to DONE.
- stall is combinational: (IDLE & start & ~flush) | BUSY. DONE does not stall, so the issuing instruction leaves E on the DONE cycle.
- BUSY: one iteration per cycle; count increments; after WIDTH iterations (count==WIDTH-1 processed) next state DONE. Latency for a nonzero op: start cycle + WIDTH BUSY cycles, so done is high in cycle WIDTH+1 after the start edge.
- Multiply: 2W-bit accumulator; if multiplier bit set add shifted multiplicand; shift right. Divide: restoring, one partial-remainder compare/subtract per cycle, quotient bit shifted into LSB.
- Sign fixup, applied when entering DONE:
  - MULT: negate the 2W-bit product if sign(a)^sign(b).
  - DIV: quotient negated if sign(a)^sign(b); remainder takes the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0 (natural wrap, no trap).
- Divide by zero: lo=all ones, hi=srca (unmodified), divzero=1 for the done cycle. Entered from IDLE in 1 cycle.
- DONE: done=hilowrite=1 for exactly one cycle; hi/lo hold their value until the next done. Next state IDLE. A start in DONE is not accepted; it is accepted the following IDLE cycle.
- start while BUSY: ignored (pipeline is stalled, so this is the same instruction).
- flush in any state: next state IDLE, no done/hilowrite. flush beats a simultaneous start in IDLE. flush in DONE suppresses done and hilowrite.
- divzero, done and hilowrite are 0 outside DONE.

Test Plan:
- Reset mid-op:
  - Stimulus: MULTU 0x12345678*0x9ABCDEF0, drop rst at BUSY count=10.
  - Response: immediate IDLE, stall=0, no hilowrite.
  - Re-issue runs to completion: hi=0x0B00EA4E, lo=0x242D2080, done exactly 33 cycles after the start edge.
- MULT 0xFFFFFFFD (-3) * 0x00000007:
  - Response: hi=0xFFFFFFFF, lo=0xFFFFFFEB.
  - stall high for 33 cycles including the start cycle, low on the done cycle.
- DIV 0xFFFFFFF9 (-7) / 0x00000002:
  - Response: lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU 0x00000064 / 0:
  - Response: done the cycle after start, lo=0xFFFFFFFF, hi=0x00000064, divzero=1.
- Overflow divide and flush:
  - DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
  - A second op with flush at BUSY count=5: no hilowrite, and hi/lo keep the previous result.
- Concurrent inputs:
  - start+flush together in IDLE: stall=0, stays IDLE.
  - start held across DONE: only one hilowrite, then a new op begins the next IDLE cycle.
